alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 13 +
 rtl/op_timer.sv | 17 +
 rtl/alu_sequencer.sv | 88 ++++++++
 tb/tb_alu_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode classes, sequencer states and opcode classification helpers
package alu_pkg;
  localparam logic [3:0] OP_MC_FIRST = 4'b0010;
  localparam logic [3:0] OP_MC_LAST = 4'b0111;
  localparam logic [3:0] OP_SHIFT_FIRST = 4'b1100;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  function automatic logic is_multicycle(input logic [3:0] op);
    return op >= OP_MC_FIRST && op <= OP_MC_LAST;
  endfunction
  function automatic logic is_shift(input logic [3:0] op);
    return op >= OP_SHIFT_FIRST;
  endfunction
endpackage

// File: rtl/op_timer.sv
// op_timer: wait-cycle counter that flags expiry on its last permitted cycle
module op_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  assign expired = count == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues ALU ops, waits on multi-cycle units with timeout, tracks results
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] num1,
  input  logic [31:0] num2,
  output logic [63:0] op_a,
  output logic [31:0] op_b,
  output logic [3:0]  op_sel,
  input  logic [63:0] comb_result,
  output logic        unit_start,
  input  logic        unit_done,
  input  logic [63:0] unit_result,
  input  logic        unit_err,
  output logic [63:0] result,
  output logic [63:0] lastresult,
  output logic        res_valid,
  output logic        busy,
  output logic        err,
  output logic        timeout
);
  state_t state;
  logic expired;
  op_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(state == ISSUE),
    .enable(state == WAIT),
    .expired(expired)
  );
  assign req_ready = state == IDLE;
  assign busy = !req_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      op_sel <= '0;
      result <= '0;
      lastresult <= '0;
      unit_start <= 1'b0;
      res_valid <= 1'b0;
      err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      unit_start <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          op_sel <= req_op;
          // shifts operate on the previous result so they can be chained
          op_a <= is_shift(req_op) ? result : num1;
          op_b <= num2;
          err <= 1'b0;
          timeout <= 1'b0;
          unit_start <= is_multicycle(req_op);
          state <= ISSUE;
        end
        ISSUE: if (is_multicycle(op_sel)) state <= WAIT;
        else begin
          result <= comb_result;
          lastresult <= result;
          res_valid <= 1'b1;
          state <= DONE;
        end
        WAIT: if (unit_done) begin
          result <= unit_result;
          lastresult <= result;
          err <= unit_err;
          res_valid <= 1'b1;
          state <= DONE;
        end else if (expired) begin
          timeout <= 1'b1;
          res_valid <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized transactions against a transaction-level model
module tb_alu_sequencer;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_ready;
  logic [3:0] req_op = '0, op_sel;
  logic [63:0] num1 = '0, op_a, comb_result = '0, unit_result = '0, result, lastresult;
  logic [31:0] num2 = '0, op_b;
  logic unit_start, unit_done = 1'b0, unit_err = 1'b0, res_valid, busy, err, timeout;
  int checks = 0, failures = 0;
  logic [63:0] m_result = '0, m_last = '0;
  logic m_err = 1'b0, m_to = 1'b0;
  alu_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .num1(num1), .num2(num2), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .comb_result(comb_result), .unit_start(unit_start), .unit_done(unit_done),
    .unit_result(unit_result), .unit_err(unit_err), .result(result), .lastresult(lastresult),
    .res_valid(res_valid), .busy(busy), .err(err), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // d = WAIT cycle index on which the unit reports done; d >= TO means never
  task automatic do_op(input logic [3:0] op, input logic [63:0] n1, input logic [31:0] n2,
                       input logic [63:0] res, input int d, input logic uerr);
    logic mc;
    logic [63:0] exp_a;
    int extra;
    mc = (op >= 4'd2) && (op <= 4'd7);
    exp_a = (op >= 4'd12) ? m_result : n1;
    extra = 0;
    m_err = 1'b0;
    m_to = 1'b0;
    chk("idle_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    req_valid = 1'b1;
    req_op = op;
    num1 = n1;
    num2 = n2;
    comb_result = mc ? {$urandom, $urandom} : res;
    tick();
    req_valid = 1'b0;
    num1 = {$urandom, $urandom};
    chk("issue_op_a", op_a, exp_a);
    chk("issue_op_b", op_b, n2);
    chk("issue_op_sel", op_sel, op);
    chk("issue_unit_start", unit_start, mc);
    chk("issue_busy", busy, 1);
    chk("issue_err_clear", err, 0);
    chk("issue_timeout_clear", timeout, 0);
    if (!mc) begin
      tick();
      m_last = m_result;
      m_result = res;
    end else begin
      tick();
      for (int j = 0; j < TO; j++) begin
        extra += int'(unit_start) + int'(res_valid);
        req_valid = 1'($urandom_range(0, 1));
        req_op = 4'($urandom);
        num1 = {$urandom, $urandom};
        unit_done = (j == d);
        unit_result = (j == d) ? res : {$urandom, $urandom};
        unit_err = (j == d) ? uerr : 1'($urandom);
        tick();
        unit_done = 1'b0;
        if (j == d || j == TO - 1) break;
      end
      req_valid = 1'b0;
      chk("wait_no_pulses", extra, 0);
      if (d < TO) begin
        m_last = m_result;
        m_result = res;
        m_err = uerr;
      end else m_to = 1'b1;
    end
    chk("done_res_valid", res_valid, 1);
    chk("done_result", result, m_result);
    chk("done_lastresult", lastresult, m_last);
    chk("done_err", err, m_err);
    chk("done_timeout", timeout, m_to);
    chk("done_op_sel_held", op_sel, op);
    chk("done_op_a_held", op_a, exp_a);
    tick();
    chk("post_res_valid", res_valid, 0);
    chk("post_ready", req_ready, 1);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_result", result, 0);
    chk("rst_lastresult", lastresult, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_flags", {unit_start, res_valid, err, timeout}, 0);
    rst = 1'b0;
    tick();
    do_op(4'h0, 64'd5, 32'd7, 64'd12, 0, 1'b0);
    do_op(4'h3, 64'd100, 32'd33, 64'h00000003_00000001, 10, 1'b0);
    do_op(4'h2, 64'd1, 32'd2, 64'd0, 1000, 1'b0);
    do_op(4'h5, 64'd9, 32'd9, 64'hA5A5_0000_1111_2222, TO - 1, 1'b0);
    do_op(4'h0, 64'd3, 32'd4, 64'h80000001, 0, 1'b0);
    do_op(4'hC, 64'hDEAD_BEEF_0000_0000, 32'd1, 64'h0000_0001_0000_0002, 0, 1'b0);
    do_op(4'h3, 64'd9, 32'd0, 64'd0, 4, 1'b1);
    do_op(4'h1, 64'd9, 32'd2, 64'd7, 0, 1'b0);
    unit_done = 1'b1;
    unit_result = 64'hFFFF_0000_FFFF_0000;
    tick();
    unit_done = 1'b0;
    chk("idle_done_ignored", result, m_result);
    chk("idle_done_no_valid", res_valid, 0);
    req_valid = 1'b1;
    req_op = 4'h4;
    num1 = 64'd77;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrst_regs", {result, lastresult, op_a, 32'(op_b), 32'(op_sel)}, 0);
    chk("wrst_flags", {unit_start, res_valid, err, timeout, busy}, 0);
    chk("wrst_ready", req_ready, 1);
    unit_done = 1'b1;
    unit_result = 64'h1234_5678_9ABC_DEF0;
    tick();
    unit_done = 1'b0;
    chk("wrst_late_done", result, 0);
    chk("wrst_late_valid", res_valid, 0);
    m_result = '0;
    m_last = '0;
    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(0, 15)), {$urandom, $urandom}, $urandom, {$urandom, $urandom},
            ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 15)), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
